// File: rtl/hicore_icb_splitter.sv
// ICB 1-to-2 address splitter: routes commands by address decode and returns
// responses in command order using a small FIFO of port selects.
module hicore_icb_splitter #(
    parameter int unsigned     AW         = 32,
    parameter int unsigned     DW         = 32,
    parameter int unsigned     OUTS_DEPTH = 4,
    parameter logic [AW-1:0]   S0_BASE    = AW'(32'h8000_0000),
    parameter logic [AW-1:0]   S0_MASK    = AW'(32'hF000_0000)
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_icb_cmd_valid,
    output logic              i_icb_cmd_ready,
    input  logic [AW-1:0]     i_icb_cmd_addr,
    input  logic              i_icb_cmd_read,
    input  logic [DW-1:0]     i_icb_cmd_wdata,
    input  logic [DW/8-1:0]   i_icb_cmd_wmask,

    output logic              i_icb_rsp_valid,
    input  logic              i_icb_rsp_ready,
    output logic              i_icb_rsp_err,
    output logic [DW-1:0]     i_icb_rsp_rdata,

    output logic              o0_icb_cmd_valid,
    input  logic              o0_icb_cmd_ready,
    output logic [AW-1:0]     o0_icb_cmd_addr,
    output logic              o0_icb_cmd_read,
    output logic [DW-1:0]     o0_icb_cmd_wdata,
    output logic [DW/8-1:0]   o0_icb_cmd_wmask,

    input  logic              o0_icb_rsp_valid,
    output logic              o0_icb_rsp_ready,
    input  logic              o0_icb_rsp_err,
    input  logic [DW-1:0]     o0_icb_rsp_rdata,

    output logic              o1_icb_cmd_valid,
    input  logic              o1_icb_cmd_ready,
    output logic [AW-1:0]     o1_icb_cmd_addr,
    output logic              o1_icb_cmd_read,
    output logic [DW-1:0]     o1_icb_cmd_wdata,
    output logic [DW/8-1:0]   o1_icb_cmd_wmask,

    input  logic              o1_icb_rsp_valid,
    output logic              o1_icb_rsp_ready,
    input  logic              o1_icb_rsp_err,
    input  logic [DW-1:0]     o1_icb_rsp_rdata
);

    localparam int unsigned PW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    logic [OUTS_DEPTH-1:0] fifo_q, fifo_d;
    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [CW-1:0]         cnt_q,  cnt_d;

    logic sel;
    logic head;
    logic full;
    logic empty;
    logic push;
    logic pop;

    assign sel   = ((i_icb_cmd_addr & S0_MASK) == S0_BASE) ? 1'b0 : 1'b1;
    assign full  = (cnt_q == CW'(OUTS_DEPTH));
    assign empty = (cnt_q == '0);
    assign head  = fifo_q[rptr_q];

    assign o0_icb_cmd_addr  = i_icb_cmd_addr;
    assign o0_icb_cmd_read  = i_icb_cmd_read;
    assign o0_icb_cmd_wdata = i_icb_cmd_wdata;
    assign o0_icb_cmd_wmask = i_icb_cmd_wmask;
    assign o1_icb_cmd_addr  = i_icb_cmd_addr;
    assign o1_icb_cmd_read  = i_icb_cmd_read;
    assign o1_icb_cmd_wdata = i_icb_cmd_wdata;
    assign o1_icb_cmd_wmask = i_icb_cmd_wmask;

    assign o0_icb_cmd_valid = i_icb_cmd_valid & ~full & ~sel;
    assign o1_icb_cmd_valid = i_icb_cmd_valid & ~full &  sel;
    assign i_icb_cmd_ready  = (sel ? o1_icb_cmd_ready : o0_icb_cmd_ready) & ~full;

    // Only the port at the FIFO head may hand back a response; the other stalls.
    assign o0_icb_rsp_ready = i_icb_rsp_ready & ~empty & ~head;
    assign o1_icb_rsp_ready = i_icb_rsp_ready & ~empty &  head;
    assign i_icb_rsp_valid  = ~empty & (head ? o1_icb_rsp_valid : o0_icb_rsp_valid);
    assign i_icb_rsp_rdata  = head ? o1_icb_rsp_rdata : o0_icb_rsp_rdata;
    assign i_icb_rsp_err    = head ? o1_icb_rsp_err   : o0_icb_rsp_err;

    assign push = i_icb_cmd_valid & i_icb_cmd_ready;
    assign pop  = i_icb_rsp_valid & i_icb_rsp_ready;

    always_comb begin
        fifo_d = fifo_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push) begin
            fifo_d[wptr_q] = sel;
            wptr_d         = wptr_q + PW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_q <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            fifo_q <= fifo_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hicore_icb_splitter.sv
// Bench for hicore_icb_splitter: directed scenarios followed by random traffic,
// checked against a queue model of outstanding port selects.
module tb_hicore_icb_splitter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_icb_cmd_valid, i_icb_cmd_ready, i_icb_cmd_read;
    logic [31:0] i_icb_cmd_addr, i_icb_cmd_wdata;
    logic [3:0]  i_icb_cmd_wmask;
    logic        i_icb_rsp_valid, i_icb_rsp_ready, i_icb_rsp_err;
    logic [31:0] i_icb_rsp_rdata;
    logic        o0_icb_cmd_valid, o0_icb_cmd_ready, o0_icb_cmd_read;
    logic [31:0] o0_icb_cmd_addr, o0_icb_cmd_wdata;
    logic [3:0]  o0_icb_cmd_wmask;
    logic        o0_icb_rsp_valid, o0_icb_rsp_ready, o0_icb_rsp_err;
    logic [31:0] o0_icb_rsp_rdata;
    logic        o1_icb_cmd_valid, o1_icb_cmd_ready, o1_icb_cmd_read;
    logic [31:0] o1_icb_cmd_addr, o1_icb_cmd_wdata;
    logic [3:0]  o1_icb_cmd_wmask;
    logic        o1_icb_rsp_valid, o1_icb_rsp_ready, o1_icb_rsp_err;
    logic [31:0] o1_icb_rsp_rdata;

    hicore_icb_splitter #(
        .AW(32), .DW(32), .OUTS_DEPTH(DEPTH),
        .S0_BASE(32'h8000_0000), .S0_MASK(32'hF000_0000)
    ) dut (
        .clk(clk), .rst(rst),
        .i_icb_cmd_valid(i_icb_cmd_valid), .i_icb_cmd_ready(i_icb_cmd_ready),
        .i_icb_cmd_addr(i_icb_cmd_addr), .i_icb_cmd_read(i_icb_cmd_read),
        .i_icb_cmd_wdata(i_icb_cmd_wdata), .i_icb_cmd_wmask(i_icb_cmd_wmask),
        .i_icb_rsp_valid(i_icb_rsp_valid), .i_icb_rsp_ready(i_icb_rsp_ready),
        .i_icb_rsp_err(i_icb_rsp_err), .i_icb_rsp_rdata(i_icb_rsp_rdata),
        .o0_icb_cmd_valid(o0_icb_cmd_valid), .o0_icb_cmd_ready(o0_icb_cmd_ready),
        .o0_icb_cmd_addr(o0_icb_cmd_addr), .o0_icb_cmd_read(o0_icb_cmd_read),
        .o0_icb_cmd_wdata(o0_icb_cmd_wdata), .o0_icb_cmd_wmask(o0_icb_cmd_wmask),
        .o0_icb_rsp_valid(o0_icb_rsp_valid), .o0_icb_rsp_ready(o0_icb_rsp_ready),
        .o0_icb_rsp_err(o0_icb_rsp_err), .o0_icb_rsp_rdata(o0_icb_rsp_rdata),
        .o1_icb_cmd_valid(o1_icb_cmd_valid), .o1_icb_cmd_ready(o1_icb_cmd_ready),
        .o1_icb_cmd_addr(o1_icb_cmd_addr), .o1_icb_cmd_read(o1_icb_cmd_read),
        .o1_icb_cmd_wdata(o1_icb_cmd_wdata), .o1_icb_cmd_wmask(o1_icb_cmd_wmask),
        .o1_icb_rsp_valid(o1_icb_rsp_valid), .o1_icb_rsp_ready(o1_icb_rsp_ready),
        .o1_icb_rsp_err(o1_icb_rsp_err), .o1_icb_rsp_rdata(o1_icb_rsp_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int mq[$];          // port select of each outstanding command, oldest first
    bit m_push, m_pop;
    int m_sel;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        i_icb_cmd_valid  = 1'b0; i_icb_cmd_addr = '0; i_icb_cmd_read = 1'b0;
        i_icb_cmd_wdata  = '0;   i_icb_cmd_wmask = '0; i_icb_rsp_ready = 1'b0;
        o0_icb_cmd_ready = 1'b1; o1_icb_cmd_ready = 1'b1;
        o0_icb_rsp_valid = 1'b0; o0_icb_rsp_err = 1'b0; o0_icb_rsp_rdata = '0;
        o1_icb_rsp_valid = 1'b0; o1_icb_rsp_err = 1'b0; o1_icb_rsp_rdata = '0;
    endtask

    task automatic cmd(input logic [31:0] addr, input logic rd);
        i_icb_cmd_valid = 1'b1;
        i_icb_cmd_addr  = addr;
        i_icb_cmd_read  = rd;
        i_icb_cmd_wdata = $urandom;
        i_icb_cmd_wmask = 4'($urandom);
    endtask

    // Compare every DUT output against the queue model for the current inputs.
    task automatic eval();
        bit full, empty, exp_rv;
        int head;
        #4;
        full  = (mq.size() == DEPTH);
        empty = (mq.size() == 0);
        m_sel = ((i_icb_cmd_addr & 32'hF000_0000) == 32'h8000_0000) ? 0 : 1;
        head  = empty ? -1 : mq[0];
        chk("o0_cmd_valid", o0_icb_cmd_valid, i_icb_cmd_valid && !full && m_sel == 0);
        chk("o1_cmd_valid", o1_icb_cmd_valid, i_icb_cmd_valid && !full && m_sel == 1);
        chk("cmd_ready", i_icb_cmd_ready,
            !full && (m_sel == 0 ? o0_icb_cmd_ready : o1_icb_cmd_ready));
        chk("o0_bcast", {o0_icb_cmd_addr, o0_icb_cmd_read, o0_icb_cmd_wdata, o0_icb_cmd_wmask},
            {i_icb_cmd_addr, i_icb_cmd_read, i_icb_cmd_wdata, i_icb_cmd_wmask});
        chk("o1_bcast", {o1_icb_cmd_addr, o1_icb_cmd_read, o1_icb_cmd_wdata, o1_icb_cmd_wmask},
            {i_icb_cmd_addr, i_icb_cmd_read, i_icb_cmd_wdata, i_icb_cmd_wmask});
        exp_rv = (head == 0 && o0_icb_rsp_valid) || (head == 1 && o1_icb_rsp_valid);
        chk("rsp_valid", i_icb_rsp_valid, exp_rv);
        chk("o0_rsp_ready", o0_icb_rsp_ready, head == 0 && i_icb_rsp_ready);
        chk("o1_rsp_ready", o1_icb_rsp_ready, head == 1 && i_icb_rsp_ready);
        if (exp_rv)
            chk("rsp_data", {i_icb_rsp_err, i_icb_rsp_rdata},
                head == 0 ? {o0_icb_rsp_err, o0_icb_rsp_rdata} : {o1_icb_rsp_err, o1_icb_rsp_rdata});
        m_push = i_icb_cmd_valid && !full && (m_sel == 0 ? o0_icb_cmd_ready : o1_icb_cmd_ready);
        m_pop  = exp_rv && i_icb_rsp_ready;
    endtask

    task automatic adv();
        @(posedge clk);
        if (m_pop)  void'(mq.pop_front());
        if (m_push) mq.push_back(m_sel);
        #1;
    endtask

    task automatic step();
        eval();
        adv();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        o0_icb_rsp_valid = 1'b1; o1_icb_rsp_valid = 1'b1; i_icb_rsp_ready = 1'b1;
        #3;
        chk("rst_rsp_valid", i_icb_rsp_valid, 1'b0);
        chk("rst_o0_rsp_ready", o0_icb_rsp_ready, 1'b0);
        chk("rst_o1_rsp_ready", o1_icb_rsp_ready, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        idle();
        mq.delete();

        // Read to port 0, response the next cycle
        cmd(32'h8000_0010, 1'b1);
        eval();
        chk("r25_o0_valid", o0_icb_cmd_valid, 1'b1);
        chk("r25_o1_valid", o1_icb_cmd_valid, 1'b0);
        adv();
        idle();
        o0_icb_rsp_valid = 1'b1; o0_icb_rsp_rdata = 32'h1234_5678; i_icb_rsp_ready = 1'b1;
        eval();
        chk("r25_rdata", i_icb_rsp_rdata, 32'h1234_5678);
        chk("r25_err", i_icb_rsp_err, 1'b0);
        adv();

        // Write routed to the default port
        idle();
        cmd(32'h1000_0000, 1'b0);
        i_icb_cmd_wmask = 4'hF;
        eval();
        chk("r26_o1_valid", o1_icb_cmd_valid, 1'b1);
        chk("r26_o1_wmask", o1_icb_cmd_wmask, 4'hF);
        adv();
        idle();
        o1_icb_rsp_valid = 1'b1; i_icb_rsp_ready = 1'b1;
        eval();
        chk("r26_rsp", {i_icb_rsp_valid, i_icb_rsp_err, i_icb_rsp_rdata}, {1'b1, 1'b0, 32'h0});
        adv();

        // Ordering: A to o1, B to o0, o0 answers first
        idle();
        cmd(32'h1000_0004, 1'b1); step();
        cmd(32'h8000_0004, 1'b1); step();
        idle();
        i_icb_rsp_ready = 1'b1;
        o0_icb_rsp_valid = 1'b1; o0_icb_rsp_rdata = 32'hBBBB_0000;
        eval();
        chk("r27_o0_stall", o0_icb_rsp_ready, 1'b0);
        chk("r27_no_valid", i_icb_rsp_valid, 1'b0);
        adv();
        o1_icb_rsp_valid = 1'b1; o1_icb_rsp_rdata = 32'hAAAA_0000;
        eval();
        chk("r27_first_A", i_icb_rsp_rdata, 32'hAAAA_0000);
        chk("r27_o0_still", o0_icb_rsp_ready, 1'b0);
        adv();
        o1_icb_rsp_valid = 1'b0;
        eval();
        chk("r27_then_B", {i_icb_rsp_valid, i_icb_rsp_rdata}, {1'b1, 32'hBBBB_0000});
        chk("r27_o0_ready", o0_icb_rsp_ready, 1'b1);
        adv();

        // Full: four outstanding block the fifth until one pops
        idle();
        cmd(32'h2000_0000, 1'b1);
        for (int i = 0; i < DEPTH; i++) step();
        eval();
        chk("r28_full_ready", i_icb_cmd_ready, 1'b0);
        chk("r28_full_valids", {o0_icb_cmd_valid, o1_icb_cmd_valid}, 2'b00);
        adv();
        o1_icb_rsp_valid = 1'b1; i_icb_rsp_ready = 1'b1;
        eval();
        chk("r28_pop_valid", i_icb_rsp_valid, 1'b1);
        chk("r28_same_cycle", i_icb_cmd_ready, 1'b0);
        adv();
        o1_icb_rsp_valid = 1'b0;
        eval();
        chk("r28_accept", i_icb_cmd_ready, 1'b1);
        adv();
        i_icb_cmd_valid = 1'b0; o1_icb_rsp_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) step();
        eval();
        chk("r28_drained", i_icb_rsp_valid, 1'b0);
        adv();

        // Simultaneous push and pop at count 2
        idle();
        cmd(32'h8000_0020, 1'b1); step();
        cmd(32'h3000_0000, 1'b1); step();
        cmd(32'h8000_0100, 1'b1);
        o0_icb_rsp_valid = 1'b1; o0_icb_rsp_rdata = 32'h0000_0001; i_icb_rsp_ready = 1'b1;
        eval();
        chk("r29_push", i_icb_cmd_ready, 1'b1);
        chk("r29_pop", i_icb_rsp_valid, 1'b1);
        adv();
        i_icb_cmd_valid = 1'b0;
        o0_icb_rsp_rdata = 32'h0000_0003;
        o1_icb_rsp_valid = 1'b1; o1_icb_rsp_rdata = 32'h0000_0002;
        eval();
        chk("r29_second", i_icb_rsp_rdata, 32'h0000_0002);
        adv();
        eval();
        chk("r29_third", i_icb_rsp_rdata, 32'h0000_0003);
        adv();
        eval();
        chk("r29_empty", i_icb_rsp_valid, 1'b0);
        adv();

        // Reset with three outstanding
        idle();
        cmd(32'h8000_0030, 1'b1);
        for (int i = 0; i < 3; i++) step();
        idle();
        o0_icb_rsp_valid = 1'b1; i_icb_rsp_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("r30_rst_valid", i_icb_rsp_valid, 1'b0);
        chk("r30_rst_ready", o0_icb_rsp_ready, 1'b0);
        mq.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        idle();
        cmd(32'h8000_0000, 1'b1);
        eval();
        chk("r30_cmd", {i_icb_cmd_ready, o0_icb_cmd_valid}, 2'b11);
        adv();
        idle();
        o0_icb_rsp_valid = 1'b1; o0_icb_rsp_rdata = 32'hCAFE_F00D; i_icb_rsp_ready = 1'b1;
        eval();
        chk("r30_rsp", {i_icb_rsp_valid, i_icb_rsp_rdata}, {1'b1, 32'hCAFE_F00D});
        adv();

        // Random traffic against the queue model
        for (int n = 0; n < 400; n++) begin
            i_icb_cmd_valid  = 1'($urandom);
            i_icb_cmd_addr   = ($urandom_range(0, 1) != 0) ? {4'h8, 28'($urandom)} : $urandom;
            i_icb_cmd_read   = 1'($urandom);
            i_icb_cmd_wdata  = $urandom;
            i_icb_cmd_wmask  = 4'($urandom);
            o0_icb_cmd_ready = ($urandom_range(0, 3) != 0);
            o1_icb_cmd_ready = ($urandom_range(0, 3) != 0);
            o0_icb_rsp_valid = 1'($urandom);
            o1_icb_rsp_valid = 1'($urandom);
            o0_icb_rsp_err   = 1'($urandom);
            o1_icb_rsp_err   = 1'($urandom);
            o0_icb_rsp_rdata = $urandom;
            o1_icb_rsp_rdata = $urandom;
            i_icb_rsp_ready  = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hicore_icb_splitter.md
HICORE_ICB_SPLITTER -- requirements
Module: hicore_icb_splitter

Interface
REQ-001 SHALL have parameter AW, default 32, meaning address width.
REQ-002 SHALL have parameter DW, default 32, meaning data width (multiple of 8).
REQ-003 SHALL have parameter OUTS_DEPTH, default 4, meaning max outstanding commands (power of 2, >=2).
REQ-004 SHALL have parameter S0_BASE, default 32'h8000_0000, meaning port-0 region base.
REQ-005 SHALL have parameter S0_MASK, default 32'hF000_0000, meaning port-0 decode mask.
REQ-006 SHALL have one clock and asynchronous active-high reset: clk input 1 (clock, rising edge); rst input 1 (asynchronous, active-high reset).
REQ-007 SHALL provide upstream command ports: i_icb_cmd_valid in 1; i_icb_cmd_ready out 1; i_icb_cmd_addr in AW; i_icb_cmd_read in 1; i_icb_cmd_wdata in DW; i_icb_cmd_wmask in DW/8.
REQ-008 SHALL provide upstream response ports: i_icb_rsp_valid out 1; i_icb_rsp_ready in 1; i_icb_rsp_err out 1; i_icb_rsp_rdata out DW.
REQ-009 SHALL provide, for n in {0,1}, downstream command ports: on_icb_cmd_valid out 1; on_icb_cmd_ready in 1; on_icb_cmd_addr out AW; on_icb_cmd_read out 1; on_icb_cmd_wdata out DW; on_icb_cmd_wmask out DW/8.
REQ-010 SHALL provide, for n in {0,1}, downstream response ports: on_icb_rsp_valid in 1; on_icb_rsp_ready out 1; on_icb_rsp_err in 1; on_icb_rsp_rdata in DW.

Function
REQ-011 SHALL decode sel=0 when (i_icb_cmd_addr & S0_MASK)==S0_BASE, else sel=1 (default port, normally the nop slave).
REQ-012 SHALL broadcast addr/read/wdata/wmask unchanged to both output ports.
REQ-013 SHALL drive o{sel}_icb_cmd_valid = i_icb_cmd_valid & !full and drive the other port's cmd_valid to 0.
REQ-014 SHALL drive i_icb_cmd_ready = o{sel}_icb_cmd_ready & !full; full depends on registered count only, not on a same-cycle pop.
REQ-015 SHALL push sel into an OUTS_DEPTH-entry in-order FIFO on each upstream cmd handshake (valid & ready).
REQ-016 SHALL derive head from the FIFO read entry and assert only o{head}_icb_rsp_ready = i_icb_rsp_ready & !empty; the other port's rsp_ready SHALL be 0.
REQ-017 SHALL drive i_icb_rsp_valid = !empty & o{head}_icb_rsp_valid, and pass i_icb_rsp_rdata/err from port head unchanged.
REQ-018 SHALL pop the FIFO on each upstream rsp handshake.
REQ-019 SHALL keep responses in command order: a response from the non-head port SHALL stall (rsp_ready=0) until its entry reaches head.
REQ-020 SHALL use a count of width clog2(OUTS_DEPTH)+1: push only -> +1; pop only -> -1; push and pop together -> unchanged; pointers wrap modulo OUTS_DEPTH.
REQ-021 SHALL block commands when count==OUTS_DEPTH (full) and SHALL never pop when count==0 (empty); a response in the same cycle as its own command SHALL be accepted no earlier than the next cycle.
REQ-022 SHALL have latency zero (combinational pass-through) on both the command and response paths, with no data registered.

Reset
REQ-023 SHALL, while rst=1 (asynchronously), clear read/write pointers and count, giving empty: i_icb_rsp_valid=0 and o0/o1_icb_rsp_ready=0.
REQ-024 SHALL, on reset asserted mid-operation, discard outstanding entries; the first command after release SHALL be accepted normally.

Verification
REQ-025 SHALL pass: read to 0x8000_0010, o0 ready=1 -> o0_icb_cmd_valid=1, o1=0; o0 rsp rdata 0x1234_5678 next cycle -> i_icb_rsp_rdata=0x1234_5678, err=0.
REQ-026 SHALL pass: write to 0x1000_0000, wmask 4'hF -> routed to o1; o1 rsp rdata 0, err 0 -> upstream rsp 0, err 0.
REQ-027 SHALL pass: cmd A to o1 then cmd B to o0 back-to-back; o0 responds first -> o0_icb_rsp_ready=0 until A's response is delivered; upstream order A then B.
REQ-028 SHALL pass: 4 commands with no responses -> 5th cycle i_icb_cmd_ready=0, both cmd_valid=0; one response popped -> 5th command accepted the following cycle.
REQ-029 SHALL pass: count=2, push and pop in the same cycle -> count remains 2 and FIFO order is preserved.
REQ-030 SHALL pass: rst asserted with 3 outstanding -> i_icb_rsp_valid=0 immediately; after release, a new command to 0x8000_0000 completes normally.
